fir_mac_sequencer: RTL and testbench

- Time-multiplexed FIR engine for the audio DSP subsystem: one shared signed 16x16 multiplier computes all N taps sequentially.
- Runs on the fast system clock. Samples arrive via a valid/ready handshake from the codec sample strobe; results return with a one-cycle valid pulse.
- Feeds the filter input of the output mux.
- Owns a run-time programmable coefficient bank, written through a simple config port.

---
 rtl/dsp_pkg.sv | 14 +
 rtl/fir_coeff_bank.sv | 37 +++
 rtl/fir_mac_sequencer.sv | 127 ++++++++++++
 tb/tb_fir_mac_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared constants and FSM encoding for the audio DSP FIR engine.
package dsp_pkg;
  localparam int DSP_SAMPLE_W = 16;
  localparam int DSP_N_TAPS   = 21;
  localparam int DSP_ACC_W    = 37;
  localparam int Q15_SHIFT    = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;
endpackage

// File: rtl/fir_coeff_bank.sv
// N_TAPS x SAMPLE_W coefficient register file: one synchronous write port,
// one combinational read port, registered reject flag for illegal writes.
module fir_coeff_bank
  import dsp_pkg::*;
#(
  parameter int N_TAPS   = DSP_N_TAPS,
  parameter int SAMPLE_W = DSP_SAMPLE_W,
  parameter int IDX_W    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr,
  input  logic                       allow,
  input  logic [5:0]                 addr,
  input  logic signed [SAMPLE_W-1:0] data,
  input  logic [IDX_W-1:0]           rd_addr,
  output logic signed [SAMPLE_W-1:0] rd_data,
  output logic                       reject
);
  logic signed [SAMPLE_W-1:0] mem [N_TAPS];
  logic in_range;
  logic wr_ok;

  assign in_range = ({1'b0, addr} < 7'(N_TAPS));
  assign wr_ok    = wr && in_range && allow;
  assign rd_data  = mem[rd_addr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_TAPS; i++) mem[i] <= '0;
      reject <= 1'b0;
    end else begin
      reject <= wr && !wr_ok;
      if (wr_ok) mem[addr[IDX_W-1:0]] <= data;
    end
  end
endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one shared signed multiplier walks all taps per sample.
// Optional output clamping is enabled by defining FIR_SATURATE_EN.
module fir_mac_sequencer
  import dsp_pkg::*;
#(
  parameter int N_TAPS   = DSP_N_TAPS,
  parameter int SAMPLE_W = DSP_SAMPLE_W,
  parameter int ACC_W    = DSP_ACC_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_sample,
  input  logic                       coeff_wr,
  input  logic [5:0]                 coeff_addr,
  input  logic signed [SAMPLE_W-1:0] coeff_data,
  output logic                       cfg_err,
  output logic                       busy,
  output state_e                     fsm_state
);
  localparam int IDX_W  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam int PROD_W = 2 * SAMPLE_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_TAPS - 1);

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE out of reset, and the source holds in_valid
  // and in_sample until that edge.
  state_e state, state_next;
  logic accept, mac_en, drain_en, out_en;
  logic [IDX_W-1:0] wr_ptr, rd_ptr, k;
  logic signed [SAMPLE_W-1:0] x [N_TAPS];
  logic signed [SAMPLE_W-1:0] coeff_rd;
  logic signed [PROD_W-1:0] mul_a, mul_b, prod_reg;
  logic signed [ACC_W-1:0] acc;
  logic signed [SAMPLE_W-1:0] out_next;

  assign fsm_state = state;

  fir_coeff_bank #(.N_TAPS(N_TAPS), .SAMPLE_W(SAMPLE_W), .IDX_W(IDX_W)) u_bank (
    .clock   (clock),
    .reset   (reset),
    .wr      (coeff_wr),
    .allow   (state == IDLE),
    .addr    (coeff_addr),
    .data    (coeff_data),
    .rd_addr (k),
    .rd_data (coeff_rd),
    .reject  (cfg_err)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MAC;
      MAC:     if (k == LAST) state_next = DRAIN;
      DRAIN:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = reset && (state == IDLE);
    busy     = reset && (state != IDLE);
    accept   = in_valid && in_ready;
    mac_en   = (state == MAC);
    drain_en = (state == DRAIN);
    out_en   = (state == OUT);
  end

  assign mul_a = PROD_W'(coeff_rd);
  assign mul_b = PROD_W'(x[rd_ptr]);

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;
  logic signed [ACC_W-1:0] shifted;
  always_comb begin
    shifted = acc >>> Q15_SHIFT;
    if (shifted > SAT_MAX)      out_next = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (shifted < SAT_MIN) out_next = {1'b1, {(SAMPLE_W-1){1'b0}}};
    else                        out_next = shifted[SAMPLE_W-1:0];
  end
`else
  assign out_next = SAMPLE_W'(acc >>> Q15_SHIFT);
`endif

  // prod_reg lags the tap index by one cycle, so the first MAC cycle adds
  // nothing and DRAIN folds in the last product.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_TAPS; i++) x[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      k          <= '0;
      prod_reg   <= '0;
      acc        <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= out_en;
      if (accept) begin
        x[wr_ptr] <= in_sample;
        wr_ptr    <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        rd_ptr    <= wr_ptr;
        k         <= '0;
        acc       <= '0;
      end
      if (mac_en) begin
        prod_reg <= mul_a * mul_b;
        if (k != '0) acc <= acc + ACC_W'(prod_reg);
        k        <= (k == LAST) ? '0 : k + 1'b1;
        rd_ptr   <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
      end
      if (drain_en) acc <= acc + ACC_W'(prod_reg);
      if (out_en) out_sample <= out_next;
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a reference FIR model feeding
// an expected-output queue.
module tb_fir_mac_sequencer;
  import dsp_pkg::*;
  localparam int N   = DSP_N_TAPS;
  localparam int LAT = N + 3;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic signed [15:0] in_sample;
  logic              in_ready;
  logic              out_valid;
  logic signed [15:0] out_sample;
  logic              coeff_wr;
  logic [5:0]        coeff_addr;
  logic signed [15:0] coeff_data;
  logic              cfg_err;
  logic              busy;
  state_e            fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  int n_err = 0;
  logic [15:0] last_out = '0;
  logic [15:0] exp_q[$];
  int acc_q[$];
  int acc_log[$];
  int coef[N];
  int hist[N];

  fir_mac_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .coeff_wr   (coeff_wr),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      coef[i] = 0;
      hist[i] = 0;
    end
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic model_accept(input int s);
    longint sum = 0;
    longint sh;
    for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    for (int i = 0; i < N; i++) sum += longint'(coef[i]) * longint'(hist[i]);
    sh = sum >>> 15;
`ifdef FIR_SATURATE_EN
    if (sh > 32767) sh = 32767;
    if (sh < -32768) sh = -32768;
`endif
    exp_q.push_back(sh[15:0]);
  endtask

  // scoreboard: push on accept, pop and compare on out_valid
  always @(negedge clock) begin
    if (in_valid && in_ready) begin
      model_accept(int'(in_sample));
      acc_q.push_back(cyc + 1);
      acc_log.push_back(cyc + 1);
      n_acc++;
    end
    if (out_valid) begin
      n_out++;
      if (exp_q.size() == 0) chk("unexpected_out_valid", 16'd1, 16'd0);
      else begin
        logic [15:0] e;
        int a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("out_sample", out_sample, e);
        // out_valid is seen high at the edge after this negedge
        chk("latency", 16'(cyc + 1 - a), 16'(LAT));
        last_out = out_sample;
      end
    end
    if (cfg_err) n_err++;
  end

  // driver tasks
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_out_sample", out_sample, 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_cfg_err", 16'(cfg_err), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_state", 16'(fsm_state), 16'(IDLE));
    @(posedge clock); #1;
    model_clear();
    reset = 1'b1;
    #1;
    chk("rst_release_ready", 16'(in_ready), 16'd1);
  endtask

  task automatic wr_coeff(input int addr, input int data, input bit legal);
    coeff_wr   = 1'b1;
    coeff_addr = 6'(addr);
    coeff_data = 16'(data);
    if (legal) coef[addr] = data;
    @(posedge clock); #1;
    coeff_wr = 1'b0;
  endtask

  task automatic send(input int s);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clock); #1;
      t++;
    end
    chk("send_ready", 16'(in_ready), 16'd1);
    in_valid  = 1'b1;
    in_sample = 16'(s);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(exp_q.size() == 0 && in_ready) && t < 400) begin
      @(posedge clock); #1;
      t++;
    end
    chk("idle_timeout", 16'(exp_q.size() == 0 && in_ready), 16'd1);
  endtask

  initial begin
    int e0, v0, base;
    reset = 1'b0; in_valid = 1'b0; in_sample = '0;
    coeff_wr = 1'b0; coeff_addr = '0; coeff_data = '0;
    model_clear();
    @(posedge clock); #1;
    do_reset();

    // impulse response with ramp coefficients
    e0 = n_err;
    for (int k = 0; k < N; k++) wr_coeff(k, 1024 * (k + 1), 1'b1);
    chk("legal_writes_no_err", 16'(n_err - e0), 16'd0);
    send(32767);
    for (int j = 0; j < N; j++) send(0);
    wait_idle();
    chk("impulse_tail", last_out, 16'd0);

    // single-tap gain of one half
    wr_coeff(0, 16384, 1'b1);
    for (int k = 1; k < N; k++) wr_coeff(k, 0, 1'b1);
    send(1000);
    wait_idle();
    chk("gain_pos", last_out, 16'd500);
    send(-1000);
    wait_idle();
    chk("gain_neg", last_out, 16'hFE0C);

    // write and accept on the same edge: new coefficient applies
    in_valid = 1'b1; in_sample = 16'sd1000;
    coeff_wr = 1'b1; coeff_addr = 6'd0; coeff_data = 16'sd8192;
    coef[0] = 8192;
    @(posedge clock); #1;
    in_valid = 1'b0; coeff_wr = 1'b0;
    wait_idle();
    chk("same_edge_write", last_out, 16'd250);

    // in_valid held high: back-to-back accepts
    base = n_acc;
    in_valid = 1'b1; in_sample = 16'sd2000;
    @(posedge clock); #1;
    repeat (5) @(posedge clock);
    #1;
    chk("held_in_ready_low", 16'(in_ready), 16'd0);
    chk("held_busy_high", 16'(busy), 16'd1);
    for (int t = 0; t < 100 && n_acc < base + 3; t++) begin
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    chk("held_accepts", 16'(n_acc - base), 16'd3);
    wait_idle();
    chk("spacing_0", 16'(acc_log[base+1] - acc_log[base]), 16'(LAT));
    chk("spacing_1", 16'(acc_log[base+2] - acc_log[base+1]), 16'(LAT));

    // rejected writes: during MAC, and out-of-range address in IDLE
    e0 = n_err;
    send(1000);
    repeat (4) @(posedge clock);
    #1;
    wr_coeff(0, 123, 1'b0);
    wait_idle();
    chk("cfg_err_mac", 16'(n_err - e0), 16'd1);
    chk("coeff_kept_1", last_out, 16'd250);
    send(1000);
    wait_idle();
    chk("coeff_kept_2", last_out, 16'd250);
    e0 = n_err;
    wr_coeff(21, 77, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("cfg_err_addr", 16'(n_err - e0), 16'd1);

    // overflow: full-scale coefficients and samples
    for (int k = 0; k < N; k++) wr_coeff(k, 32767, 1'b1);
    for (int j = 0; j < N; j++) send(32767);
    wait_idle();
`ifdef FIR_SATURATE_EN
    chk("overflow", last_out, 16'h7FFF);
`else
    chk("overflow", last_out, 16'h7FD6);
`endif

    // reset mid-computation at tap 10
    send(777);
    repeat (10) @(posedge clock);
    #1;
    v0 = n_out;
    do_reset();
    repeat (40) @(posedge clock);
    #1;
    chk("abort_no_out_valid", 16'(n_out - v0), 16'd0);
    chk("abort_out_sample", out_sample, 16'd0);
    send(12345);
    wait_idle();
    chk("post_reset_zero", last_out, 16'd0);
    chk("post_reset_outputs", 16'(n_out - v0), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
